crc10_check: RTL and testbench
==============================

// Module: crc10_check
// PURPOSE
//  Receive-side checker for CRC10 (x^10+x^9+x^5+x^4+x+1) on 32-bit word frames.
//  Consumes a valid/ready stream: data beats, then one trailer beat carrying the CRC.
//  Recomputes the CRC over the data beats, compares it with the trailer, and reports
//  pass/fail with a one-cycle done pulse. Sits at the receive end of the link whose
//  transmit side appends the CRC10.
// PARAMETERS
//  MAX_WORDS  64      max data beats per frame (trailer excluded); beyond -> length error
//  CRC_INIT   10'h000 CRC register value at frame start
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous reset, active low
//  s_valid      in   1   input beat valid
//  s_ready      out  1   checker can accept a beat
//  s_data       in   32  data word; on the trailer beat, CRC in [9:0], [31:10] must be 0
//  s_last       in   1   marks the trailer beat
//  chk_done     out  1   1-cycle pulse: frame result valid
//  chk_ok       out  1   CRC matched, format ok, length ok (valid with chk_done)
//  chk_err_crc  out  1   computed CRC != trailer[9:0]
//  chk_err_fmt  out  1   trailer[31:10] != 0
//  chk_err_len  out  1   data beats > MAX_WORDS
//  crc_calc     out  10  CRC computed over the data beats of the last frame
//  word_cnt     out  7   data beats in the last frame, saturating at MAX_WORDS+1
// BEHAVIOUR
//  - Reset: state IDLE; s_ready=1; chk_* outputs=0; crc_calc=0; word_cnt=0; crc reg=CRC_INIT.
//  - Beat accepted when s_valid & s_ready.
//  - CRC per bit, bits processed in order s_data[0] first through s_data[31] last:
//    fb=crc[9]^d; crc={crc[8:0],1'b0}^(fb?10'h233:10'h0). A full 32-bit step is done
//    combinationally per accepted data beat; trailer beats are not folded in.
//  - FSM:
//    IDLE  : s_ready=1; the first accepted beat starts a frame (crc reg <= CRC_INIT).
//            A non-last beat -> DATA. A last beat (zero-length frame) -> CHECK.
//    DATA  : s_ready=1; each non-last beat updates crc and count.
//            Count exceeds MAX_WORDS -> DROP. Last beat -> CHECK.
//    DROP  : s_ready=1; beats are consumed and ignored; last beat -> CHECK with err_len.
//    CHECK : exactly one cycle; s_ready=0; chk_done=1 with results -> IDLE.
//  - Latency: trailer accepted on edge N -> chk_done high during cycle N+1.
//    Next frame can be accepted from cycle N+2.
//  - Results register: compare against the captured trailer. chk_ok = ~(err_crc|err_fmt|err_len).
//    err_crc is not evaluated when err_len=1 (held 0).
//  - chk_ok, chk_err_*, crc_calc and word_cnt hold until the next CHECK.
//    chk_done is low outside CHECK.
//  - s_valid low mid-frame: hold state, no timeout.
//  - rst_n low mid-frame: immediate abort to the reset values; no chk_done is issued
//    for the aborted frame.
//  - word_cnt saturates at MAX_WORDS+1 and does not wrap.
// STRUCTURE
//  - Shared package/header: CRC10_POLY=10'h233, CRC10_W=10, state encodings
//    (IDLE, DATA, DROP, CHECK), and function crc10_step32(crc, word), so that the
//    transmit generator uses the identical step.
//  - One sub-module is natural: crc10_step32 (pure combinational 32-bit update),
//    shared with the generator. Everything else (FSM, counter, result registers)
//    stays in crc10_check.
// TESTING
//  1. Data 32'h00000000, trailer 32'h00000000 -> chk_done@N+1, chk_ok=1, crc_calc=10'h000.
//  2. Data 32'h80000000, trailer 32'h00000233 -> chk_ok=1, crc_calc=10'h233, word_cnt=1.
//  3. Data 32'h80000000, trailer 32'h00000232 -> chk_err_crc=1, chk_ok=0.
//  4. Data 32'h80000000, trailer 32'h00010233 -> chk_err_fmt=1, chk_err_crc=0, chk_ok=0.
//  5. MAX_WORDS+1 zero beats then trailer 0 -> chk_err_len=1, word_cnt=MAX_WORDS+1,
//     s_ready stays 1 until trailer. Then back-to-back frame 2 passes with no stall
//     beyond the CHECK cycle.
//  6. Assert rst_n=0 after 3 data beats -> outputs at reset values, no chk_done.
//     Frame 2 after release -> chk_ok=1.

Source files
------------

// File: rtl/crc10_check_pkg.sv
// CRC10 receive checker: shared constants, FSM encoding and the
// 32-bit CRC step so the transmit generator computes the identical value.
package crc10_check_pkg;

    localparam int CRC10_W = 10;
    localparam logic [CRC10_W-1:0] CRC10_POLY = 10'h233;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_DROP  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    // Bit 0 of the word is shifted in first, bit 31 last.
    function automatic logic [CRC10_W-1:0] crc10_step32(
        input logic [CRC10_W-1:0] crc,
        input logic [31:0]        word
    );
        logic [CRC10_W-1:0] c;
        logic               fb;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            fb = c[CRC10_W-1] ^ word[i];
            c  = {c[CRC10_W-2:0], 1'b0} ^ (fb ? CRC10_POLY : '0);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc10_check_if.sv
// Valid/ready beat stream carrying 32-bit words plus a last marker.
// master: drives valid/data/last; slave: drives ready.
interface crc10_check_if;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/crc10_check_step32.sv
// Pure combinational CRC10 update over one 32-bit word.
// Ports: crc_i (current CRC), data_i (word), crc_o (updated CRC).
module crc10_check_step32
    import crc10_check_pkg::*;
(
    input  logic [CRC10_W-1:0] crc_i,
    input  logic [31:0]        data_i,
    output logic [CRC10_W-1:0] crc_o
);

    assign crc_o = crc10_step32(crc_i, data_i);

endmodule

// File: rtl/crc10_check.sv
// CRC10 frame checker: data beats then a trailer beat holding the CRC.
// Ports: clk, rst_n, s (stream slave), chk_* results, crc_calc, word_cnt.
module crc10_check
    import crc10_check_pkg::*;
#(
    parameter int                 MAX_WORDS = 64,
    parameter logic [CRC10_W-1:0] CRC_INIT  = 10'h000,
    localparam int                CNT_W     = $clog2(MAX_WORDS + 2)
) (
    input  logic                clk,
    input  logic                rst_n,
    crc10_check_if.slave        s,
    output logic                chk_done,
    output logic                chk_ok,
    output logic                chk_err_crc,
    output logic                chk_err_fmt,
    output logic                chk_err_len,
    output logic [CRC10_W-1:0]  crc_calc,
    output logic [CNT_W-1:0]    word_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WORDS + 1);

    state_t             state_q, state_d;
    logic [CRC10_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CRC10_W-1:0] crc_calc_q, crc_calc_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               ok_q, ok_d;
    logic               err_crc_q, err_crc_d;
    logic               err_fmt_q, err_fmt_d;
    logic               err_len_q, err_len_d;

    logic               accept;
    logic [CRC10_W-1:0] crc_base;
    logic [CRC10_W-1:0] crc_next;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_inc;
    logic               len_err;
    logic               fmt_err;
    logic               crc_err;

    assign accept = s.s_valid & s.s_ready;

    // In IDLE the first beat starts a fresh frame, so the running
    // state is ignored and the step starts from the init values.
    assign crc_base = (state_q == S_IDLE) ? CRC_INIT : crc_q;
    assign cnt_base = (state_q == S_IDLE) ? '0 : cnt_q;
    assign cnt_inc  = (cnt_base == CNT_SAT) ? CNT_SAT : cnt_base + 1'b1;

    assign len_err = (state_q == S_DROP);
    assign fmt_err = |s.s_data[31:CRC10_W];
    assign crc_err = ~len_err & (s.s_data[CRC10_W-1:0] != crc_base);

    crc10_check_step32 u_step (
        .crc_i  (crc_base),
        .data_i (s.s_data),
        .crc_o  (crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            crc_q      <= CRC_INIT;
            cnt_q      <= '0;
            crc_calc_q <= '0;
            word_cnt_q <= '0;
            ok_q       <= 1'b0;
            err_crc_q  <= 1'b0;
            err_fmt_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            crc_calc_q <= crc_calc_d;
            word_cnt_q <= word_cnt_d;
            ok_q       <= ok_d;
            err_crc_q  <= err_crc_d;
            err_fmt_q  <= err_fmt_d;
            err_len_q  <= err_len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DATA: begin
                if (accept) begin
                    if (s.s_last) begin
                        state_d = S_CHECK;
                    end else if (cnt_inc > CNT_MAX) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DROP: begin
                if (accept && s.s_last) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Results are registered on the trailer edge so they are
    // already valid during the CHECK cycle when chk_done is high.
    always_comb begin
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        crc_calc_d = crc_calc_q;
        word_cnt_d = word_cnt_q;
        ok_d       = ok_q;
        err_crc_d  = err_crc_q;
        err_fmt_d  = err_fmt_q;
        err_len_d  = err_len_q;
        if (accept && !s.s_last) begin
            cnt_d = cnt_inc;
            if (state_q != S_DROP) begin
                crc_d = crc_next;
            end
        end
        if (accept && s.s_last) begin
            crc_d      = CRC_INIT;
            cnt_d      = '0;
            crc_calc_d = crc_base;
            word_cnt_d = cnt_base;
            err_len_d  = len_err;
            err_fmt_d  = fmt_err;
            err_crc_d  = crc_err;
            ok_d       = ~(len_err | fmt_err | crc_err);
        end
    end

    always_comb begin
        s.s_ready   = (state_q != S_CHECK);
        chk_done    = (state_q == S_CHECK);
        chk_ok      = ok_q;
        chk_err_crc = err_crc_q;
        chk_err_fmt = err_fmt_q;
        chk_err_len = err_len_q;
        crc_calc    = crc_calc_q;
        word_cnt    = word_cnt_q;
    end

endmodule

// File: tb/tb_crc10_check.sv
// Directed bench for crc10_check: frame results, latency, length
// overflow, stalls and mid-frame reset, with hand-computed expectations.
module tb_crc10_check;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chk_done;
    logic       chk_ok;
    logic       chk_err_crc;
    logic       chk_err_fmt;
    logic       chk_err_len;
    logic [9:0] crc_calc;
    logic [6:0] word_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    crc10_check_if ifc ();

    crc10_check #(
        .MAX_WORDS (64),
        .CRC_INIT  (10'h000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (ifc.slave),
        .chk_done    (chk_done),
        .chk_ok      (chk_ok),
        .chk_err_crc (chk_err_crc),
        .chk_err_fmt (chk_err_fmt),
        .chk_err_len (chk_err_len),
        .crc_calc    (crc_calc),
        .word_cnt    (word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat; returns the cycles spent waiting for ready.
    task automatic beat(input logic [31:0] d, input logic l,
                        output int waits);
        waits = 0;
        ifc.s_valid = 1'b1;
        ifc.s_data  = d;
        ifc.s_last  = l;
        while (!ifc.s_ready && waits < 8) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (waits >= 8) begin
            tests++;
            fails++;
            $error("FAIL beat_timeout observed=%0d expected=<8", waits);
        end
        @(posedge clk);
        #1;
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
        ifc.s_data  = '0;
    endtask

    task automatic result(input string tag, input logic ok,
                          input logic ec, input logic ef, input logic el,
                          input logic [9:0] calc, input logic [6:0] cnt);
        chk({tag, "_done"}, chk_done, 1'b1);
        chk({tag, "_ok"}, chk_ok, ok);
        chk({tag, "_ecrc"}, chk_err_crc, ec);
        chk({tag, "_efmt"}, chk_err_fmt, ef);
        chk({tag, "_elen"}, chk_err_len, el);
        chk({tag, "_calc"}, crc_calc, calc);
        chk({tag, "_cnt"}, word_cnt, cnt);
    endtask

    initial begin
        int w;
        int wsum;
        int dones;
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        ifc.s_last  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ifc.s_ready, 1'b1);
        chk("rst_done", chk_done, 1'b0);
        chk("rst_ok", chk_ok, 1'b0);
        chk("rst_calc", crc_calc, 10'h000);
        chk("rst_cnt", word_cnt, 7'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        beat(32'h0000_0000, 1'b0, w);
        beat(32'h0000_0000, 1'b1, w);
        result("t1", 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 7'd1);
        chk("t1_ready_check", ifc.s_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("t1_done_low", chk_done, 1'b0);
        chk("t1_ready_back", ifc.s_ready, 1'b1);
        chk("t1_ok_hold", chk_ok, 1'b1);

        beat(32'h8000_0000, 1'b0, w);
        beat(32'h0000_0233, 1'b1, w);
        result("t2", 1'b1, 1'b0, 1'b0, 1'b0, 10'h233, 7'd1);

        beat(32'h8000_0000, 1'b0, w);
        beat(32'h0000_0232, 1'b1, w);
        result("t3", 1'b0, 1'b1, 1'b0, 1'b0, 10'h233, 7'd1);

        beat(32'h8000_0000, 1'b0, w);
        beat(32'h0001_0233, 1'b1, w);
        result("t4", 1'b0, 1'b0, 1'b1, 1'b0, 10'h233, 7'd1);

        beat(32'h0000_0005, 1'b1, w);
        result("zl_bad", 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 7'd0);
        beat(32'h0000_0000, 1'b1, w);
        result("zl_ok", 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 7'd0);

        beat(32'h8000_0000, 1'b0, w);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_nodone", chk_done, 1'b0);
        beat(32'h0000_0233, 1'b1, w);
        result("stall", 1'b1, 1'b0, 1'b0, 1'b0, 10'h233, 7'd1);

        @(posedge clk);
        #1;
        wsum = 0;
        for (int i = 0; i < 65; i++) begin
            beat(32'h0000_0000, 1'b0, w);
            wsum += w;
        end
        chk("t5_ready_held", wsum, 0);
        beat(32'h0000_0000, 1'b1, w);
        result("t5", 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 7'd65);
        beat(32'h8000_0000, 1'b0, w);
        chk("t5_b2b_wait", w, 1);
        beat(32'h0000_0233, 1'b1, w);
        chk("t5_b2b_trl_wait", w, 0);
        result("t5_b2b", 1'b1, 1'b0, 1'b0, 1'b0, 10'h233, 7'd1);

        @(posedge clk);
        #1;
        for (int i = 0; i < 70; i++) begin
            beat(32'h0000_0000, 1'b0, w);
        end
        beat(32'h0000_0232, 1'b1, w);
        result("sat", 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 7'd65);

        @(posedge clk);
        #1;
        beat(32'h8000_0000, 1'b0, w);
        beat(32'h0000_0000, 1'b0, w);
        beat(32'h8000_0000, 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ready", ifc.s_ready, 1'b1);
        chk("t6_done", chk_done, 1'b0);
        chk("t6_elen", chk_err_len, 1'b0);
        chk("t6_cnt", word_cnt, 7'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (chk_done) dones++;
        end
        chk("t6_no_done", dones, 0);
        beat(32'h8000_0000, 1'b0, w);
        beat(32'h0000_0233, 1'b1, w);
        result("t6_f2", 1'b1, 1'b0, 1'b0, 1'b0, 10'h233, 7'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
